// File: rtl/pattern_frame_ctrl.sv
// pattern_frame_ctrl
// -----------------------------------------------------------------------------
// Frame-timing controller for the pattern generator. Sequences active pixels,
// horizontal blank after every line and vertical blank after the last line,
// drives the external 5-bit line counter (line_enb / new_line), cross-checks
// the counter's end_frame flag, and selects the pattern shown in each frame.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin sequencing (only honoured in IDLE)
//   stop         : request stop, latched while busy, applied at frame end
//   auto_adv     : advance pattern_id at every frame end
//   pat_load     : load pat_in into pattern_id (only honoured in IDLE)
//   pat_in       : pattern to load
//   end_frame    : end-of-frame flag from the line counter
//   line_enb     : line counter enable (high whenever busy)
//   new_line     : strobe on the last HBLANK cycle of each line
//   pix_valid    : high during active pixels
//   pix_x        : pixel index (zero-extended to 8 bits)
//   line_y       : line index
//   pattern_id   : active pattern
//   frame_start  : pulse on the first active pixel of a frame
//   frame_done   : pulse on the last VBLANK cycle
//   busy         : high whenever not IDLE
//   sync_err     : sticky line counter / controller disagreement
//
// Handshake/timing: all outputs are flops. Every decision is taken on the
// rising clk edge from the current registered state plus the inputs present
// during that cycle; the result is visible in the following cycle.
// -----------------------------------------------------------------------------
module pattern_frame_ctrl #(
    parameter int PIX_PER_LINE    = 64,
    parameter int HBLANK_CYC      = 8,
    parameter int LINES_PER_FRAME = 32,
    parameter int VBLANK_CYC      = 16,
    parameter int NUM_PATTERNS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       auto_adv,
    input  logic       pat_load,
    input  logic [1:0] pat_in,
    input  logic       end_frame,
    output logic       line_enb,
    output logic       new_line,
    output logic       pix_valid,
    output logic [7:0] pix_x,
    output logic [4:0] line_y,
    output logic [1:0] pattern_id,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    localparam logic [7:0]  PIX_LAST    = 8'(PIX_PER_LINE - 1);
    localparam logic [4:0]  LINE_LAST   = 5'(LINES_PER_FRAME - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(HBLANK_CYC - 1);
    localparam logic [15:0] VBLANK_LAST = 16'(VBLANK_CYC - 1);
    localparam logic [1:0]  PAT_LAST    = 2'(NUM_PATTERNS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;          // blank-cycle counter (HBLANK and VBLANK)
    logic [7:0]  pix_x_q, pix_x_d;
    logic [4:0]  line_y_q, line_y_d;
    logic [1:0]  pat_q, pat_d;
    logic        stop_q, stop_d;        // pending stop request
    logic        err_q, err_d;
    logic        pix_valid_q, pix_valid_d;
    logic        line_enb_q, line_enb_d;
    logic        busy_q, busy_d;
    logic        new_line_q, new_line_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        stop_hit;

    // A stop arriving on the very last VBLANK cycle still ends this frame.
    assign stop_hit = stop_q | stop;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pix_x_d       = pix_x_q;
        line_y_d      = line_y_q;
        pat_d         = pat_q;
        stop_d        = stop_q;
        err_d         = err_q;
        frame_start_d = 1'b0;

        // new_line_q marks the cycle the line counter sees the strobe; its
        // end_frame answer for that line is sampled at the end of the cycle.
        if (new_line_q && (end_frame != (line_y_q == LINE_LAST))) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pat_load) begin
                    pat_d = pat_in;
                end
                if (start) begin
                    state_d       = ACTIVE;
                    pix_x_d       = 8'd0;
                    line_y_d      = 5'd0;
                    frame_start_d = 1'b1;
                    err_d         = 1'b0;
                    // start+stop together runs exactly one frame
                    stop_d        = stop;
                end
            end
            ACTIVE: begin
                stop_d = stop_hit;
                if (pix_x_q == PIX_LAST) begin
                    state_d = HBLANK;
                    cnt_d   = 16'd0;
                end else begin
                    pix_x_d = pix_x_q + 8'd1;
                end
            end
            HBLANK: begin
                stop_d = stop_hit;
                if (cnt_q == HBLANK_LAST) begin
                    if (line_y_q == LINE_LAST) begin
                        state_d = VBLANK;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d  = ACTIVE;
                        line_y_d = line_y_q + 5'd1;
                        pix_x_d  = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            VBLANK: begin
                stop_d = stop_hit;
                if (cnt_q == VBLANK_LAST) begin
                    if (auto_adv) begin
                        pat_d = (pat_q >= PAT_LAST) ? 2'd0 : pat_q + 2'd1;
                    end
                    pix_x_d  = 8'd0;
                    line_y_d = 5'd0;
                    if (stop_hit) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d       = ACTIVE;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        pix_valid_d  = (state_d == ACTIVE);
        line_enb_d   = (state_d != IDLE);
        busy_d       = (state_d != IDLE);
        new_line_d   = (state_d == HBLANK) && (cnt_d == HBLANK_LAST);
        frame_done_d = (state_d == VBLANK) && (cnt_d == VBLANK_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 16'd0;
            pix_x_q       <= 8'd0;
            line_y_q      <= 5'd0;
            pat_q         <= 2'd0;
            stop_q        <= 1'b0;
            err_q         <= 1'b0;
            pix_valid_q   <= 1'b0;
            line_enb_q    <= 1'b0;
            busy_q        <= 1'b0;
            new_line_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pix_x_q       <= pix_x_d;
            line_y_q      <= line_y_d;
            pat_q         <= pat_d;
            stop_q        <= stop_d;
            err_q         <= err_d;
            pix_valid_q   <= pix_valid_d;
            line_enb_q    <= line_enb_d;
            busy_q        <= busy_d;
            new_line_q    <= new_line_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign line_enb    = line_enb_q;
    assign new_line    = new_line_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign line_y      = line_y_q;
    assign pattern_id  = pat_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_pattern_frame_ctrl.sv
module tb_pattern_frame_ctrl;

  localparam int P    = 4;
  localparam int H    = 2;
  localparam int L    = 3;
  localparam int V    = 3;
  localparam int NP   = 4;
  localparam int PER  = P + H;
  localparam int ACT  = L * PER;
  localparam int FLEN = ACT + V;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 0, stop = 0, auto_adv = 0, pat_load = 0, end_frame = 0;
  logic [1:0] pat_in = 0;
  logic       line_enb, new_line, pix_valid, frame_start, frame_done, busy, sync_err;
  logic [7:0] pix_x;
  logic [4:0] line_y;
  logic [1:0] pattern_id;

  pattern_frame_ctrl #(
    .PIX_PER_LINE(P), .HBLANK_CYC(H), .LINES_PER_FRAME(L),
    .VBLANK_CYC(V), .NUM_PATTERNS(NP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .auto_adv(auto_adv),
    .pat_load(pat_load), .pat_in(pat_in), .end_frame(end_frame),
    .line_enb(line_enb), .new_line(new_line), .pix_valid(pix_valid),
    .pix_x(pix_x), .line_y(line_y), .pattern_id(pattern_id),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .sync_err(sync_err)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_pat = 0;
  logic       exp_err = 0;
  logic       stop_pend = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, busy=%0b required finish", busy);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Accept a frame from IDLE; returns during the frame's first cycle.
  task automatic start_frame(input bit with_stop, input bit with_load, input logic [1:0] ld);
    start     = 1;
    stop      = with_stop;
    pat_load  = with_load;
    pat_in    = ld;
    stop_pend = with_stop;
    if (with_load) exp_pat = ld;
    exp_err = 0;
    tick;
    start    = 0;
    stop     = 0;
    pat_load = 0;
  endtask

  // Checks every cycle of one frame against a position-in-frame model.
  task automatic run_frame(input int stop_cyc, input bit hold_start, input bit bad_line0);
    logic [21:0] e, a;
    int ln, pos, px;
    bit pv, nl;
    for (int t = 0; t < FLEN; t++) begin
      if (t < ACT) begin
        ln  = t / PER;
        pos = t % PER;
        pv  = (pos < P);
        px  = pv ? pos : P - 1;
        nl  = (pos == PER - 1);
      end else begin
        ln = L - 1;
        px = P - 1;
        pv = 0;
        nl = 0;
      end
      e = {1'b1, nl, pv, 8'(px), 5'(ln), exp_pat, (t == 0), (t == FLEN - 1), 1'b1, exp_err};
      a = {line_enb, new_line, pix_valid, pix_x, line_y, pattern_id,
           frame_start, frame_done, busy, sync_err};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL frame_t%0d: got le/nl/pv/px/ly/pat/fs/fd/busy/err=%b required %b", t, a, e);
      end
      // stimulus for this cycle, sampled at the next edge
      end_frame = (ln == L - 1);
      if (bad_line0 && ln == 0) end_frame = 1;
      stop     = (t == stop_cyc);
      start    = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      pat_load = 1'($urandom_range(0, 1));
      pat_in   = 2'($urandom_range(0, 3));
      stop_pend = stop_pend | stop;
      if (nl && (end_frame != (ln == L - 1))) exp_err = 1;
      tick;
    end
    start    = 0;
    stop     = 0;
    pat_load = 0;
    if (auto_adv) exp_pat = 2'((int'(exp_pat) + 1) % NP);
    if (stop_pend) begin
      stop_pend = 0;
      a = {14'd0, busy, line_enb, pix_valid, new_line, frame_start, frame_done, pattern_id};
      e = {14'd0, 6'b0, exp_pat};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL idle_after_stop: got busy/le/pv/nl/fs/fd/pat=%b required %b", a[7:0], e[7:0]);
      end
      n_tests++;
      if (sync_err !== exp_err) begin
        n_fail++;
        $display("FAIL idle_sync_err: got %b required %b", sync_err, exp_err);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    n_tests++;
    if ({line_enb, new_line, pix_valid, pix_x, line_y, pattern_id, frame_start,
         frame_done, busy, sync_err} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b pix_x=%0d line_y=%0d required all 0", busy, pix_x, line_y);
    end
    tick;
    rst = 0;
    stop = 1;
    tick;
    tick;
    stop = 0;
    n_tests++;
    if ({busy, line_enb, pix_valid, frame_start} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b le=%b required 0", busy, line_enb);
    end
  endtask

  task automatic test_single_frame;
    auto_adv = 0;
    start_frame(0, 0, 2'd0);
    run_frame(-1, 0, 0);
    run_frame($urandom_range(0, FLEN - 1), 0, 0);
  endtask

  task automatic test_stop;
    start_frame(0, 0, 2'd0);
    run_frame(4, 0, 0);
    stop = 1;
    tick;
    tick;
    stop = 0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_in_idle: got busy=%b required 0", busy);
    end
    start_frame(1, 0, 2'd0);
    run_frame(-1, 0, 0);
  endtask

  task automatic test_pattern;
    logic [1:0] r;
    for (int k = 0; k < 3; k++) begin
      r = 2'($urandom_range(0, 3));
      pat_load = 1;
      pat_in = r;
      tick;
      pat_load = 0;
      exp_pat = r;
      n_tests++;
      if (pattern_id !== r) begin
        n_fail++;
        $display("FAIL idle_pat_load: got %0d required %0d", pattern_id, r);
      end
    end
    auto_adv = 1;
    start_frame(0, 1, 2'd3);
    run_frame(-1, 0, 0);
    run_frame(-1, 0, 0);
    run_frame($urandom_range(0, FLEN - 1), 0, 0);
    auto_adv = 0;
    start_frame(0, 1, 2'd3);
    run_frame(-1, 0, 0);
    run_frame(FLEN - 1, 0, 0);
  endtask

  task automatic test_sync_err;
    start_frame(0, 0, 2'd0);
    run_frame(-1, 0, 0);
    run_frame($urandom_range(0, FLEN - 1), 0, 1);
    start_frame(0, 0, 2'd0);
    run_frame(0, 0, 0);
  endtask

  task automatic test_rst_mid;
    start_frame(0, 0, 2'd0);
    for (int t = 0; t < P + 1; t++) begin
      end_frame = 0;
      tick;
    end
    rst = 1;
    #1;
    n_tests++;
    if ({line_enb, new_line, pix_valid, pix_x, line_y, pattern_id, frame_start,
         frame_done, busy, sync_err} !== 22'd0) begin
      n_fail++;
      $display("FAIL async_rst_mid: got busy=%b pix_x=%0d line_y=%0d pat=%0d required all 0",
               busy, pix_x, line_y, pattern_id);
    end
    tick;
    tick;
    rst = 0;
    exp_pat = 0;
    exp_err = 0;
    stop_pend = 0;
    tick;
    tick;
    n_tests++;
    if ({busy, pix_valid, pix_x, line_y} !== 15'd0) begin
      n_fail++;
      $display("FAIL idle_after_rst: got busy=%b pix_x=%0d line_y=%0d required 0", busy, pix_x, line_y);
    end
    start_frame(0, 0, 2'd0);
    run_frame($urandom_range(0, FLEN - 1), 0, 0);
  endtask

  task automatic test_back_to_back;
    auto_adv = 1'($urandom_range(0, 1));
    start_frame(0, 1, 2'($urandom_range(0, 3)));
    run_frame(-1, 1, 0);
    run_frame(-1, 1, 0);
    run_frame($urandom_range(0, FLEN - 1), 1, 0);
    auto_adv = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_single_frame;
    test_stop;
    test_pattern;
    test_sync_err;
    test_rst_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_frame_ctrl.md
Name: pattern_frame_ctrl

Overview:
- Frame-timing controller that sequences the 5-bit line counter and the pattern generator datapath.
- Runs the pixel, horizontal-blank and vertical-blank timing.
- Drives the counter's enable and new-line strobes, and cross-checks the counter's end-of-frame flag.
- Selects the active pattern per frame. Sits between the host start/stop controls and the pattern datapath.

Parameters:
PIX_PER_LINE, 64, active pixels per line (2..256)
HBLANK_CYC, 8, blank cycles after each line (>=1)
LINES_PER_FRAME, 32, lines per frame (2..32, matches 5-bit line counter)
VBLANK_CYC, 16, blank cycles after last line (>=1)
NUM_PATTERNS, 4, pattern count for auto-advance (1..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin frame sequencing (level sampled; only honoured in IDLE)
stop  in  1  request stop; latched, takes effect at next frame end
auto_adv  in  1  1 = pattern_id advances each frame
pat_load  in  1  load pat_in into pattern_id (honoured only in IDLE)
pat_in  in  2  pattern to load
end_frame  in  1  end-of-frame flag from line counter
line_enb  out  1  enable to line counter
new_line  out  1  one-cycle strobe at end of each line's blank
pix_valid  out  1  high during active pixels
pix_x  out  8  current pixel index
line_y  out  5  current line index
pattern_id  out  2  active pattern
frame_start  out  1  one-cycle pulse on first active pixel of a frame
frame_done  out  1  one-cycle pulse on last VBLANK cycle
busy  out  1  high whenever state != IDLE
sync_err  out  1  sticky counter/controller mismatch flag

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0. The stop latch is cleared.
- All outputs are registered. Decisions are made on the rising clk edge.
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - pix_valid=0, line_enb=0, busy=0.
  - pat_load=1 sets pattern_id<=pat_in.
  - start=1: next cycle is ACTIVE, with pix_x=0, line_y=0 and frame_start=1 for that cycle. sync_err is cleared.
  - start and pat_load together: the load applies and the frame starts.
- ACTIVE:
  - pix_valid=1, line_enb=1.
  - pix_x increments each cycle.
  - When pix_x==PIX_PER_LINE-1, go to HBLANK next cycle. pix_x holds at its last value.
- HBLANK:
  - pix_valid=0, line_enb=1.
  - The internal counter runs HBLANK_CYC cycles. new_line=1 on the last HBLANK cycle only.
  - On that cycle, if line_y==LINES_PER_FRAME-1, go to VBLANK.
  - Otherwise line_y++, pix_x<=0, and go to ACTIVE.
- VBLANK:
  - line_enb=1, pix_valid=0.
  - Lasts VBLANK_CYC cycles. frame_done=1 on the last cycle.
  - On that cycle:
    - If auto_adv=1, pattern_id <= (pattern_id+1) mod NUM_PATTERNS.
    - If the stop latch is set, go to IDLE and clear the latch.
    - Otherwise, go to ACTIVE with line_y=0, pix_x=0 and frame_start=1.
- Frame length: LINES_PER_FRAME*(PIX_PER_LINE+HBLANK_CYC)+VBLANK_CYC cycles.
- stop:
  - Sampled any cycle while busy and latched.
  - Never truncates a frame. stop in IDLE is ignored.
  - start and stop together in IDLE: exactly one frame runs, then the block returns to IDLE.
- start while busy: ignored. pat_load while busy: ignored. pattern_id only changes at frame_done.
- sync_err:
  - Evaluated on every new_line cycle.
  - Set if end_frame=1 while line_y!=LINES_PER_FRAME-1.
  - Set if end_frame=0 while line_y==LINES_PER_FRAME-1.
  - Sticky until the next accepted start or rst.
- Width rules:
  - pix_x is zero-extended to 8 bits.
  - line_y wraps only via the explicit reset to 0 at VBLANK exit; it never exceeds LINES_PER_FRAME-1.
- rst asserted mid-frame: immediate return to IDLE. All outputs go to 0 asynchronously, including pattern_id.

Test Plan:
- Params PIX=4, HBLANK=2, LINES=3, VBLANK=3; pulse start 1 cycle with stop=0.
  - frame_start is seen on cycle 1.
  - new_line pulses come 6 cycles apart.
  - frame_done arrives at cycle 21, and the next frame_start follows on cycle 22.
- The same setup with stop pulsed at cycle 5: the frame completes, frame_done arrives at cycle 21, busy=0 and line_enb=0 from cycle 22.
- Multi-frame pattern stepping:
  - auto_adv=1 with pat_load of pat_in=3 in IDLE, then start with stop held, NUM_PATTERNS=4: pattern_id goes 3→0 after the first frame_done.
  - auto_adv=0: pattern_id stays 3.
- end_frame model correct for the first frame, then forced to 1 on line 0 of the second frame.
  - sync_err=0 after frame 1; sync_err=1 from the line-0 new_line cycle and it stays set.
  - A new start from IDLE clears it.
- rst asserted in the middle of HBLANK:
  - All outputs are 0 without waiting for a clk edge.
  - After release, state is IDLE and start is needed to resume, with pix_x=0 and line_y=0.
- start held high continuously plus pat_load pulsed during ACTIVE: no restart and pattern_id unchanged mid-frame.
